// File: rtl/bus_responder.sv
// Purpose: CPU data-bus target; decodes mirrored work RAM, vector ROM and open bus, commits CPU writes.
// Latency: read data_valid_o rises READ_LATENCY edges after request acceptance (1..255).
// Backpressure: none; a request is held by the CPU, and an address change or drop restarts or aborts it.
// Optional RAM preload port enabled by defining BUS_RESPONDER_LOAD_EN.
module bus_responder #(
  parameter int unsigned RAM_ADDR_WIDTH = 11,
  parameter int unsigned READ_LATENCY   = 2,
  parameter logic [15:0] NMI_VECTOR     = 16'h0000,
  parameter logic [15:0] RESET_VECTOR   = 16'h8000,
  parameter logic [15:0] IRQ_VECTOR     = 16'h0000
) (
  input  logic                      clock_i,
  input  logic                      reset_ni,
  input  logic [15:0]               address_i,
  input  logic                      address_valid_i,
  input  logic [7:0]                data_i,
  input  logic                      data_valid_i,
`ifdef BUS_RESPONDER_LOAD_EN
  input  logic                      load_valid_i,
  input  logic [RAM_ADDR_WIDTH-1:0] load_address_i,
  input  logic [7:0]                load_data_i,
`endif
  output logic [7:0]                data_o,
  output logic                      data_valid_o
);

  localparam int unsigned RAM_BYTES = 1 << RAM_ADDR_WIDTH;
  localparam logic [7:0]  LAT_LAST  = 8'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } state_e;

  state_e      state_q;
  logic [15:0] addr_q;
  logic [7:0]  cnt_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic [7:0]  open_bus_q;

  logic [7:0]  ram [RAM_BYTES];

  logic        wr_edge;
  logic        ram_wr;
  logic        new_req;
  logic [15:0] vec_word;
  logic [7:0]  rd_dat_d;

  // RAM occupies 0x0000-0x1FFF, mirrored every RAM_BYTES bytes.
  function automatic logic in_ram(input logic [15:0] a);
    return (a[15:13] == 3'b000);
  endfunction

  function automatic logic in_vec(input logic [15:0] a);
    return (a >= 16'hFFFA);
  endfunction

  // A write strobe always starts a fresh request so a held read-back sees the new byte.
  assign wr_edge = address_valid_i & data_valid_i;
  // No write lands on an edge seen while reset is asserted.
  assign ram_wr  = wr_edge & in_ram(address_i) & reset_ni;
  assign new_req = address_valid_i &
                   ((state_q == IDLE) | (address_i != addr_q) | data_valid_i);

  // Read-data decode on the latched address; unmapped space returns the open-bus byte.
  always_comb begin
    vec_word = 16'h0000;
    rd_dat_d = open_bus_q;
    case (addr_q[2:1])
      2'b01:   vec_word = NMI_VECTOR;
      2'b10:   vec_word = RESET_VECTOR;
      2'b11:   vec_word = IRQ_VECTOR;
      default: vec_word = 16'h0000;
    endcase
    if (in_ram(addr_q)) begin
      rd_dat_d = ram[addr_q[RAM_ADDR_WIDTH-1:0]];
    end else if (in_vec(addr_q)) begin
      rd_dat_d = addr_q[0] ? vec_word[15:8] : vec_word[7:0];
    end
  end

`ifdef BUS_RESPONDER_LOAD_EN
  // RAM write port: preload first, CPU write last so it wins on a same-byte collision.
  always_ff @(posedge clock_i) begin
    if (load_valid_i) begin
      ram[load_address_i] <= load_data_i;
    end
    if (ram_wr) begin
      ram[address_i[RAM_ADDR_WIDTH-1:0]] <= data_i;
    end
  end
`else
  // RAM write port: CPU writes only.
  always_ff @(posedge clock_i) begin
    if (ram_wr) begin
      ram[address_i[RAM_ADDR_WIDTH-1:0]] <= data_i;
    end
  end
`endif

  // Request FSM: accept, count down the latency, present data, hold until the CPU moves on.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      addr_q     <= 16'h0000;
      cnt_q      <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      open_bus_q <= 8'h00;
    end else if (!address_valid_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else if (new_req) begin
      state_q <= WAIT;
      addr_q  <= address_i;
      cnt_q   <= LAT_LAST;
      valid_q <= 1'b0;
      // Dropped writes (vector or unmapped) still leave their byte on the bus.
      if (wr_edge && !in_ram(address_i)) begin
        open_bus_q <= data_i;
      end
    end else begin
      case (state_q)
        WAIT: begin
          if (cnt_q != 8'h00) begin
            cnt_q <= cnt_q - 8'h01;
          end else begin
            data_q     <= rd_dat_d;
            valid_q    <= 1'b1;
            open_bus_q <= rd_dat_d;
            state_q    <= VALID;
          end
        end
        VALID: begin
          state_q <= VALID;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;

endmodule
